dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port, clock-edge-synchronous data memory between the processor memory stage (requester P, priority) and a loader/peripheral port (requester L, e.g. a program loader or I/O engine). Address, data and write-enable are muxed combinationally. A starvation counter forces one L access after `MAX_WAIT` denied cycles, stalling P for that cycle. The block sits between the processor's dmem pins and `dmem`.

## Interface
- `MAX_WAIT`, default 4: consecutive denied L-request cycles before L is forced; must be ≥1.
- `clock` in 1: system clock; dmem is clocked on the same edge.
- `reset` in 1: asynchronous, active-high.
- `p_req` in 1: P wants a dmem access this cycle.
- `p_wren` in 1: P write (1) or read (0).
- `p_addr` in 12: P word address.
- `p_data` in 32: P write data.
- `p_stall` out 1: P must hold `p_*` and not advance.
- `p_q` out 32: read data to P; equals `q_dmem`.
- `l_req` in 1: L wants an access.
- `l_wren` in 1: L write/read.
- `l_addr` in 12: L word address.
- `l_data` in 32: L write data.
- `l_gnt` out 1: L access performed this cycle.
- `l_q` out 32: read data to L; equals `q_dmem`.
- `l_qvalid` out 1: `l_q` holds data for the L read granted last cycle.
- `address_dmem` out 12, `data` out 32, `wren` out 1: to dmem.
- `q_dmem` in 32: from dmem.

## Operation
- FSM states: `PROC` (P priority) and `FORCE` (L forced).
- In `PROC`:
  - `p_req` → P owns dmem, `l_gnt`=0.
  - Else `l_req` → L owns dmem, `l_gnt`=1.
  - Else no owner.
- In `FORCE`:
  - `l_req` → L owns dmem, `l_gnt`=1, `p_stall`=`p_req`.
  - `l_req` low → no L grant, P served as in `PROC`, `p_stall`=0.
- `p_stall` = (state==`FORCE`) & `l_req` & `p_req`. It is never asserted in `PROC`.
- Owner P: `address_dmem`/`data`/`wren` = `p_addr`/`p_data`/`p_wren`.
- Owner L: the same outputs = `l_addr`/`l_data`/`l_wren`.
- No owner: the outputs are 0/0/0.
- `wait_cnt` (width clog2(MAX_WAIT+1)):
  - cleared on any L grant or when `l_req`=0;
  - incremented on each cycle with `l_req`=1 and L denied.
- `PROC`→`FORCE` at the edge where L is denied and `wait_cnt`==MAX_WAIT-1.
- `FORCE`→`PROC` at the next edge, unconditionally; `wait_cnt` is cleared.
- `l_qvalid` register is set at an edge iff L was granted a read (`l_wren`=0) in the ending cycle.
- L writes never set `l_qvalid`.
- Simultaneous `p_req` & `l_req` in `PROC`: P wins; the L denial counts toward `MAX_WAIT`.
- Reset (any time, including during `FORCE` or after a granted read):
  - state=`PROC`, `wait_cnt`=0, `l_qvalid`=0 immediately;
  - `wren`=0 unless a requester asserts combinationally.
  - No access is replayed after reset.

## Timing
- Grant and mux decisions are combinational from the current state and inputs, so an access occurs in the request cycle.
- Read data latency: `q_dmem` is valid in the cycle after the access. `l_qvalid` is aligned with that cycle.
- P read data follows the processor's existing one-cycle dmem convention.
- Worst-case L wait with P continuously requesting: MAX_WAIT denied cycles, then the grant at cycle MAX_WAIT (0-based from the first request).
- P sees at most one stall cycle per MAX_WAIT+1 cycles.
- L must hold `l_*` stable until `l_gnt`. Dropping `l_req` early is legal and resets the count.
- Reset values of outputs: `p_stall` 0, `l_gnt` 0, `l_qvalid` 0, `address_dmem`/`data`/`wren` 0 when no request.

## Structure
- Shared package `dmem_arb_pkg`: `ADDR_W`=12, `DATA_W`=32, state enum {`PROC`, `FORCE`}.
- Flat module with no sub-module. The counter and FSM share enables and are kept together.

## Test plan
- Reset asserted mid-`FORCE` with an L read granted → `p_stall`, `l_gnt`, `l_qvalid` all 0 in the same cycle; state `PROC` after release.
- Only L reads addr 0x005, where dmem[5]=0xDEADBEEF → `l_gnt`=1 in cycle 0; `l_qvalid`=1 and `l_q`=0xDEADBEEF in cycle 1.
- P and L request every cycle, MAX_WAIT=4:
  - P served in cycles 0-3, `l_gnt`=1 and `p_stall`=1 in cycle 4;
  - P served cycles 5-8, forced again in cycle 9.
- L requests for 3 cycles under P traffic, drops for 1, resumes → count restarts; no force until 4 further denials.
- In cycle 4 (`FORCE`), L drops `l_req` → `p_stall`=0, P write to 0x010 with 0x12345678 lands; read-back returns 0x12345678.
- Forced L write to 0x020 with 0x0000ABCD → `wren`=1, `address_dmem`=0x020 that cycle; `l_qvalid` stays 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter between the processor
// memory stage (P) and the loader/peripheral port (L).
package dmem_arb_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  typedef enum logic {
    PROC  = 1'b0,
    FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port dmem between P (priority) and L, forcing one L
// access after MAX_WAIT consecutive denied L cycles. Mux and grant are combinational.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_wren,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_stall,
  output logic [DATA_W-1:0] p_q,
  input  logic              l_req,
  input  logic              l_wren,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_data,
  output logic              l_gnt,
  output logic [DATA_W-1:0] l_q,
  output logic              l_qvalid,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem,
  output arb_state_e        dbg_state
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  // L handshake: L holds l_* stable while l_req is high; the access happens in
  // the cycle l_gnt is 1, and read data comes back one cycle later with l_qvalid.
  arb_state_e       state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             l_qvalid_q;

  logic in_force;
  logic p_own;
  logic l_denied;
  logic cnt_hit;

  assign in_force = (state_q == FORCE);
  assign l_gnt    = l_req & (in_force | ~p_req);
  assign p_own    = p_req & ~l_gnt;
  assign p_stall  = in_force & l_req & p_req;
  assign l_denied = l_req & ~l_gnt;
  assign cnt_hit  = (wait_cnt_q == CNT_W'(MAX_WAIT - 1));

  always_comb begin
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    if (l_gnt) begin
      address_dmem = l_addr;
      data         = l_data;
      wren         = l_wren;
    end else if (p_own) begin
      address_dmem = p_addr;
      data         = p_data;
      wren         = p_wren;
    end
  end

  // FORCE lasts exactly one cycle whether or not L still wants the slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= PROC;
      wait_cnt_q <= '0;
      l_qvalid_q <= 1'b0;
    end else begin
      l_qvalid_q <= l_gnt & ~l_wren;
      case (state_q)
        FORCE: begin
          state_q    <= PROC;
          wait_cnt_q <= '0;
        end
        default: begin
          if (l_denied) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            if (cnt_hit) state_q <= FORCE;
          end else begin
            wait_cnt_q <= '0;
          end
        end
      endcase
    end
  end

  assign l_qvalid  = l_qvalid_q;
  assign p_q       = q_dmem;
  assign l_q       = q_dmem;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (MAX_WAIT=4) with a behavioural synchronous
// dmem; comb outputs are checked 1-4 time units after the rising edge.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              p_req, p_wren, l_req, l_wren;
  logic [ADDR_W-1:0] p_addr, l_addr, address_dmem;
  logic [DATA_W-1:0] p_data, l_data, data, p_q, l_q;
  logic [DATA_W-1:0] q_dmem = '0;
  logic              p_stall, l_gnt, l_qvalid, wren;
  arb_state_e        dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] mem [0:4095];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (wren) mem[address_dmem] <= data;
    q_dmem <= mem[address_dmem];
  end

  dmem_arbiter #(.MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_data(p_data),
    .p_stall(p_stall), .p_q(p_q),
    .l_req(l_req), .l_wren(l_wren), .l_addr(l_addr), .l_data(l_data),
    .l_gnt(l_gnt), .l_q(l_q), .l_qvalid(l_qvalid),
    .address_dmem(address_dmem), .data(data), .wren(wren),
    .q_dmem(q_dmem), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    p_req = 1'b0; p_wren = 1'b0; p_addr = '0; p_data = '0;
    l_req = 1'b0; l_wren = 1'b0; l_addr = '0; l_data = '0;
  endtask

  task automatic drive_p(input logic w, input logic [11:0] a, input logic [31:0] d);
    p_req = 1'b1; p_wren = w; p_addr = a; p_data = d;
  endtask

  task automatic drive_l(input logic w, input logic [11:0] a, input logic [31:0] d);
    l_req = 1'b1; l_wren = w; l_addr = a; l_data = d;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[5] = 32'hDEADBEEF;
    idle();
    reset = 1'b1;

    // Reset state, then a P request during reset still reaches dmem.
    #2;
    chk("rst_p_stall", 32'(p_stall), 32'd0);
    chk("rst_l_gnt", 32'(l_gnt), 32'd0);
    chk("rst_l_qvalid", 32'(l_qvalid), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_addr", 32'(address_dmem), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(PROC));
    drive_p(1'b1, 12'h0AB, 32'h0);
    #1;
    chk("rst_p_wren_comb", 32'(wren), 32'd1);
    idle();
    tick();
    reset = 1'b0;
    tick();

    // L-only read of address 5.
    drive_l(1'b0, 12'h005, 32'h0);
    #1;
    chk("lrd_gnt", 32'(l_gnt), 32'd1);
    chk("lrd_addr", 32'(address_dmem), 32'h005);
    chk("lrd_wren", 32'(wren), 32'd0);
    tick();
    idle();
    #1;
    chk("lrd_qvalid", 32'(l_qvalid), 32'd1);
    chk("lrd_l_q", l_q, 32'hDEADBEEF);
    chk("lrd_gnt_off", 32'(l_gnt), 32'd0);
    tick();

    // P and L both request every cycle: forced at cycles 4 and 9.
    for (int i = 0; i < 10; i++) begin
      drive_p(1'b0, 12'(12'h100 + i), 32'h0);
      drive_l(1'b0, 12'h030, 32'h0);
      #1;
      chk($sformatf("cont_gnt_%0d", i), 32'(l_gnt), 32'((i == 4) || (i == 9)));
      chk($sformatf("cont_stall_%0d", i), 32'(p_stall), 32'((i == 4) || (i == 9)));
      chk($sformatf("cont_addr_%0d", i), 32'(address_dmem),
          ((i == 4) || (i == 9)) ? 32'h030 : 32'(32'h100 + i));
      chk($sformatf("cont_qvalid_%0d", i), 32'(l_qvalid), 32'(i == 5));
      tick();
    end
    idle();
    #1;
    chk("cont_qvalid_10", 32'(l_qvalid), 32'd1);
    chk("cont_state_10", 32'(dbg_state), 32'(PROC));
    tick();

    // Three denials, drop one cycle, resume: force only after 4 new denials.
    for (int i = 0; i < 3; i++) begin
      drive_p(1'b0, 12'h200, 32'h0);
      drive_l(1'b0, 12'h031, 32'h0);
      #1;
      chk($sformatf("pre_gnt_%0d", i), 32'(l_gnt), 32'd0);
      tick();
    end
    l_req = 1'b0;
    #1;
    chk("drop_gnt", 32'(l_gnt), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive_p(1'b0, 12'h200, 32'h0);
      drive_l(1'b1, 12'h020, 32'h0000ABCD);
      #1;
      chk($sformatf("resume_gnt_%0d", i), 32'(l_gnt), 32'(i == 4));
      if (i == 4) begin
        chk("fw_wren", 32'(wren), 32'd1);
        chk("fw_addr", 32'(address_dmem), 32'h020);
        chk("fw_data", data, 32'h0000ABCD);
        chk("fw_stall", 32'(p_stall), 32'd1);
      end
      if (i < 4) tick();
    end
    tick();
    idle();
    #1;
    chk("fw_qvalid", 32'(l_qvalid), 32'd0);
    chk("fw_mem", mem[12'h020], 32'h0000ABCD);
    tick();

    // L drops its request in the FORCE cycle: P write proceeds unstalled.
    for (int i = 0; i < 4; i++) begin
      drive_p(1'b0, 12'h300, 32'h0);
      drive_l(1'b0, 12'h032, 32'h0);
      tick();
    end
    l_req = 1'b0;
    drive_p(1'b1, 12'h010, 32'h12345678);
    #1;
    chk("fdrop_state", 32'(dbg_state), 32'(FORCE));
    chk("fdrop_stall", 32'(p_stall), 32'd0);
    chk("fdrop_gnt", 32'(l_gnt), 32'd0);
    chk("fdrop_wren", 32'(wren), 32'd1);
    chk("fdrop_addr", 32'(address_dmem), 32'h010);
    chk("fdrop_data", data, 32'h12345678);
    tick();
    drive_p(1'b0, 12'h010, 32'h0);
    #1;
    chk("rb_state", 32'(dbg_state), 32'(PROC));
    chk("rb_wren", 32'(wren), 32'd0);
    tick();
    idle();
    #1;
    chk("rb_p_q", p_q, 32'h12345678);
    tick();

    // Reset mid-FORCE while an L read is granted.
    for (int i = 0; i < 4; i++) begin
      drive_p(1'b0, 12'h400, 32'h0);
      drive_l(1'b0, 12'h005, 32'h0);
      tick();
    end
    #1;
    chk("rf_gnt_before", 32'(l_gnt), 32'd1);
    chk("rf_state_before", 32'(dbg_state), 32'(FORCE));
    #1;
    reset = 1'b1;
    #1;
    chk("rf_stall", 32'(p_stall), 32'd0);
    chk("rf_gnt", 32'(l_gnt), 32'd0);
    chk("rf_qvalid", 32'(l_qvalid), 32'd0);
    chk("rf_state", 32'(dbg_state), 32'(PROC));
    tick();
    chk("rf_qvalid_held", 32'(l_qvalid), 32'd0);
    idle();
    reset = 1'b0;
    #1;
    chk("rf_state_after", 32'(dbg_state), 32'(PROC));
    chk("rf_wren_after", 32'(wren), 32'd0);
    tick();

    // Reset just after a granted L read clears l_qvalid immediately.
    drive_l(1'b0, 12'h005, 32'h0);
    tick();
    idle();
    #1;
    chk("rq_qvalid_set", 32'(l_qvalid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rq_qvalid_clr", 32'(l_qvalid), 32'd0);
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
